// File: rtl/reg_shift_sequencer.sv
// Multi-cycle register-amount shifter (LSL/LSR/ASR/ROR, ARM carry-out), STEP bits per SHIFT cycle.
// out_valid rises 1+ceil(count/STEP) cycles after accept; the result is held while out_ready=0.
module reg_shift_sequencer #(
    parameter int unsigned STEP = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  shift_type,
    input  logic [31:0] rm_data,
    input  logic [7:0]  rs_amount,
    input  logic        carry_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_carry,
    output logic        busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

    localparam logic [5:0] STEP_AMT = 6'(STEP);

    state_t      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic        carry_q, carry_d;
    logic [1:0]  type_q, type_d;
    logic [5:0]  remaining_q, remaining_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_carry_q, out_carry_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;

    logic [5:0]  count;
    logic [5:0]  step_amt;
    logic [63:0] ext;
    logic [31:0] shifted;
    logic        shifted_carry;

    // Effective shift distance; anything beyond these saturates to the same ARM result.
    always_comb begin
        count = 6'd0;
        case (shift_type)
            2'b00, 2'b01: count = (rs_amount > 8'd33) ? 6'd33 : rs_amount[5:0];
            2'b10:        count = (rs_amount > 8'd32) ? 6'd32 : rs_amount[5:0];
            default: begin
                if (rs_amount == 8'd0)
                    count = 6'd0;
                else if (rs_amount[4:0] == 5'd0)
                    count = 6'd32;
                else
                    count = {1'b0, rs_amount[4:0]};
            end
        endcase
    end

    // 64-bit windows keep a 32-bit step well defined and expose the last bit shifted out.
    always_comb begin
        step_amt      = (remaining_q > STEP_AMT) ? STEP_AMT : remaining_q;
        ext           = 64'd0;
        shifted       = data_q;
        shifted_carry = carry_q;
        case (type_q)
            2'b00: begin
                ext           = {32'd0, data_q} << step_amt;
                shifted       = ext[31:0];
                shifted_carry = ext[32];
            end
            2'b01: begin
                ext           = {data_q, 32'd0} >> step_amt;
                shifted       = ext[63:32];
                shifted_carry = ext[31];
            end
            2'b10: begin
                ext           = 64'($signed({data_q, 32'd0}) >>> step_amt);
                shifted       = ext[63:32];
                shifted_carry = ext[31];
            end
            default: begin
                ext           = {data_q, data_q} >> step_amt;
                shifted       = ext[31:0];
                shifted_carry = ext[31];
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        carry_d     = carry_q;
        type_d      = type_q;
        remaining_d = remaining_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_carry_d = out_carry_q;
        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_d      = rm_data;
                        type_d      = shift_type;
                        carry_d     = carry_in;
                        remaining_d = count;
                        state_d     = (count == 6'd0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    data_d      = shifted;
                    carry_d     = shifted_carry;
                    remaining_d = remaining_q - step_amt;
                    if (remaining_d == 6'd0)
                        state_d = ST_DONE;
                end
                ST_DONE: begin
                    // First DONE cycle publishes the result; release waits for it to be seen.
                    if (!out_valid_q) begin
                        out_valid_d = 1'b1;
                        out_data_d  = data_q;
                        out_carry_d = carry_q;
                    end else if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            data_q      <= 32'd0;
            carry_q     <= 1'b0;
            type_q      <= 2'b00;
            remaining_q <= 6'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_carry_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            carry_q     <= carry_d;
            type_q      <= type_d;
            remaining_q <= remaining_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_carry_q <= out_carry_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_carry = out_carry_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_reg_shift_sequencer.sv
// Randomized and directed checks of reg_shift_sequencer against an ARM shift reference model.
module tb_reg_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  shift_type;
    logic [31:0] rm_data;
    logic [7:0]  rs_amount;
    logic        carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_carry;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    reg_shift_sequencer #(.STEP(8)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .shift_type(shift_type), .rm_data(rm_data), .rs_amount(rs_amount), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_carry(out_carry), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Architectural result {carry, data} of an ARM register-specified shift.
    function automatic logic [32:0] ref_shift(input logic [1:0] t, input logic [31:0] rm,
                                              input logic [7:0] amt, input logic cin);
        int a;
        int r;
        logic [32:0] res;
        a = int'(amt);
        res = {cin, rm};
        if (a != 0) begin
            case (t)
                2'b00: if (a < 32) res = {rm[32-a], rm << a};
                       else if (a == 32) res = {rm[0], 32'd0};
                       else res = 33'd0;
                2'b01: if (a < 32) res = {rm[a-1], rm >> a};
                       else if (a == 32) res = {rm[31], 32'd0};
                       else res = 33'd0;
                2'b10: if (a < 32) res = {rm[a-1], 32'($signed(rm) >>> a)};
                       else res = {rm[31], {32{rm[31]}}};
                default: begin
                    r = a % 32;
                    if (r == 0) res = {rm[31], rm};
                    else res = {rm[r-1], (rm >> r) | (rm << (32 - r))};
                end
            endcase
        end
        return res;
    endfunction

    function automatic int exp_latency(input logic [1:0] t, input logic [7:0] amt);
        int a;
        int c;
        a = int'(amt);
        if (t == 2'b11) c = (a == 0) ? 0 : ((a % 32 == 0) ? 32 : a % 32);
        else if (t == 2'b10) c = (a > 32) ? 32 : a;
        else c = (a > 33) ? 33 : a;
        return (c == 0) ? 1 : 1 + (c + 7) / 8;
    endfunction

    // Present one operand set; returns cycles from accept edge until out_valid is seen.
    task automatic do_op(input logic [1:0] t, input logic [31:0] rm, input logic [7:0] amt,
                         input logic cin, output int lat, output logic [31:0] d, output logic c);
        in_valid = 1'b1; shift_type = t; rm_data = rm; rs_amount = amt; carry_in = cin;
        @(posedge clk); #1;
        in_valid = 1'b0; rm_data = $urandom; rs_amount = 8'($urandom); carry_in = ~cin;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        d = out_data;
        c = out_carry;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        shift_type = 2'b00; rm_data = 32'd0; rs_amount = 8'd0; carry_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_data, out_carry, busy, in_ready} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state: got v=%b d=%h c=%b busy=%b rdy=%b want 0/0/0/0/1",
                     out_valid, out_data, out_carry, busy, in_ready);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_ready: got rdy=%b busy=%b want 1/0", in_ready, busy);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  t;
        logic [31:0] rm, ed, d;
        logic [7:0]  amt;
        logic        cin, ec, c;
        int          el, lat;
        for (int i = 0; i < 9; i++) begin
            case (i)
                0: begin t = 2'b00; rm = 32'h000000F1; amt = 8'd4;   cin = 1'b0; ed = 32'h00000F10; ec = 1'b0; el = 2; end
                1: begin t = 2'b01; rm = 32'hFFFFFFFF; amt = 8'd40;  cin = 1'b0; ed = 32'h00000000; ec = 1'b0; el = 6; end
                2: begin t = 2'b01; rm = 32'hFFFFFFFF; amt = 8'd32;  cin = 1'b0; ed = 32'h00000000; ec = 1'b1; el = 5; end
                3: begin t = 2'b10; rm = 32'h80000000; amt = 8'd200; cin = 1'b0; ed = 32'hFFFFFFFF; ec = 1'b1; el = 5; end
                4: begin t = 2'b11; rm = 32'h0000001F; amt = 8'd4;   cin = 1'b0; ed = 32'hF0000001; ec = 1'b1; el = 2; end
                5: begin t = 2'b11; rm = 32'h80000001; amt = 8'd32;  cin = 1'b0; ed = 32'h80000001; ec = 1'b1; el = 5; end
                6: begin t = 2'b00; rm = 32'h12345678; amt = 8'd0;   cin = 1'b1; ed = 32'h12345678; ec = 1'b1; el = 1; end
                7: begin t = 2'b00; rm = 32'hFFFFFFFF; amt = 8'd33;  cin = 1'b1; ed = 32'h00000000; ec = 1'b0; el = 6; end
                default: begin t = 2'b00; rm = 32'h00000001; amt = 8'd32; cin = 1'b0; ed = 32'h00000000; ec = 1'b1; el = 5; end
            endcase
            do_op(t, rm, amt, cin, lat, d, c);
            checks++;
            if (d !== ed || c !== ec || lat !== el) begin
                failures++;
                $display("FAIL directed_%0d: got d=%h c=%b lat=%0d want d=%h c=%b lat=%0d",
                         i, d, c, lat, ed, ec, el);
            end
            pop();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL directed_release_%0d: got rdy=%b v=%b want 1/0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_zero_amount();
        for (int t = 0; t < 4; t++) begin
            in_valid = 1'b1; shift_type = 2'(t); rm_data = 32'h12345678; rs_amount = 8'd0; carry_in = 1'b1;
            out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL zero_accept_t%0d: got rdy=%b v=%b busy=%b want 0/0/1", t, in_ready, out_valid, busy);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h12345678 || out_carry !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL zero_result_t%0d: got v=%b d=%h c=%b rdy=%b want 1/12345678/1/0",
                         t, out_valid, out_data, out_carry, in_ready);
            end
            @(posedge clk); #1;
            out_ready = 1'b0;
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL zero_release_t%0d: got rdy=%b v=%b want 1/0", t, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_random();
        int corners[13] = '{0, 1, 7, 8, 9, 31, 32, 33, 34, 63, 64, 96, 255};
        logic [1:0]  t;
        logic [31:0] rm, d;
        logic [7:0]  amt;
        logic        cin, c;
        logic [32:0] exp;
        int          lat, el, hold;
        for (int n = 0; n < 80; n++) begin
            t   = 2'($urandom_range(0, 3));
            rm  = $urandom;
            cin = 1'($urandom);
            if ($urandom_range(0, 1) == 0) amt = 8'(corners[$urandom_range(0, 12)]);
            else amt = 8'($urandom_range(0, 255));
            exp = ref_shift(t, rm, amt, cin);
            el  = exp_latency(t, amt);
            do_op(t, rm, amt, cin, lat, d, c);
            checks++;
            if ({c, d} !== exp || lat !== el) begin
                failures++;
                $display("FAIL random_%0d t=%0d rm=%h amt=%0d cin=%b: got d=%h c=%b lat=%0d want d=%h c=%b lat=%0d",
                         n, t, rm, amt, cin, d, c, lat, exp[31:0], exp[32], el);
            end
            hold = $urandom_range(0, 3);
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                checks++;
                if (out_valid !== 1'b1 || {out_carry, out_data} !== exp || in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL random_hold_%0d: got v=%b d=%h c=%b rdy=%b want 1/%h/%b/0",
                             n, out_valid, out_data, out_carry, in_ready, exp[31:0], exp[32]);
                end
            end
            pop();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rm, d;
        logic        c;
        logic [32:0] exp;
        int          lat;
        rm  = $urandom | 32'h1;
        exp = ref_shift(2'b00, rm, 8'd5, 1'b0);
        do_op(2'b00, rm, 8'd5, 1'b0, lat, d, c);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || {out_carry, out_data} !== exp || in_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL backpressure_hold_%0d: got v=%b d=%h c=%b rdy=%b busy=%b want 1/%h/%b/0/1",
                         k, out_valid, out_data, out_carry, in_ready, busy, exp[31:0], exp[32]);
            end
        end
        pop();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release: got rdy=%b v=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_flush();
        int          seen, lat;
        logic [31:0] d;
        logic        c;
        in_valid = 1'b1; shift_type = 2'b00; rm_data = 32'hDEADBEEF; rs_amount = 8'd33; carry_in = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_shift: got rdy=%b v=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
        end
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL flush_no_result: got %0d valid cycles want 0", seen);
        end
        // flush beats a simultaneous accept
        in_valid = 1'b1; flush = 1'b1; rs_amount = 8'd4;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle_accept: got rdy=%b busy=%b want 1/0", in_ready, busy);
        end
        do_op(2'b01, 32'hF0000000, 8'd4, 1'b0, lat, d, c);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_done: got v=%b rdy=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int          lat;
        logic [31:0] d;
        logic        c;
        do_op(2'b00, 32'h000000F1, 8'd4, 1'b0, lat, d, c);
        pop();
        in_valid = 1'b1; shift_type = 2'b10; rm_data = 32'h80000000; rs_amount = 8'd200; carry_in = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        checks++;
        if ({out_valid, out_data, out_carry, busy, in_ready} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid_state: got v=%b d=%h c=%b busy=%b rdy=%b want 0/0/0/0/1",
                     out_valid, out_data, out_carry, busy, in_ready);
        end
        do_op(2'b11, 32'h0000001F, 8'd4, 1'b0, lat, d, c);
        checks++;
        if (d !== 32'hF0000001 || c !== 1'b1 || lat !== 2) begin
            failures++;
            $display("FAIL reset_mid_next_op: got d=%h c=%b lat=%0d want F0000001/1/2", d, c, lat);
        end
        pop();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_zero_amount();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
